// File: rtl/pcm_to_i2s_pkg.sv
// Shared I2S constants for the transmit and receive paths.
package pcm_to_i2s_pkg;

    localparam int DEF_NUMBER_OF_BITS = 8;
    localparam int DEF_SLOT_BITS      = 16;
    localparam int DEF_SCK_DIV        = 4;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/pcm_to_i2s_sck_divider.sv
// Bit-clock generator: divides clk down to a 50% duty SCK and flags the
// clk edge on which SCK falls, so the serialiser can update in lockstep.
module pcm_to_i2s_sck_divider
    import pcm_to_i2s_pkg::*;
#(
    parameter int SCK_DIV = DEF_SCK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic sck,
    output logic fall
);

    localparam int CW = $clog2(SCK_DIV);
    localparam logic [CW-1:0] RISE_AT = CW'(SCK_DIV / 2 - 1);
    localparam logic [CW-1:0] FALL_AT = CW'(SCK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          rise;

    assign rise = (div_cnt == RISE_AT);
    assign fall = (div_cnt == FALL_AT);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else begin
            div_cnt <= fall ? '0 : div_cnt + CW'(1);
            if (rise)
                sck <= 1'b1;
            else if (fall)
                sck <= 1'b0;
        end
    end

endmodule

// File: rtl/pcm_to_i2s.sv
// I2S bus-master transmitter: one-entry holding register behind a valid/ready
// handshake, loaded into per-channel shift registers at each frame start.
module pcm_to_i2s
    import pcm_to_i2s_pkg::*;
#(
    parameter int NUMBER_OF_BITS = DEF_NUMBER_OF_BITS,
    parameter int SLOT_BITS      = DEF_SLOT_BITS,
    parameter int SCK_DIV        = DEF_SCK_DIV
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [NUMBER_OF_BITS-1:0] data_left,
    input  logic [NUMBER_OF_BITS-1:0] data_right,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun
);

    localparam int PW = $clog2(SLOT_BITS);
    localparam logic [PW-1:0] LAST_POS = PW'(SLOT_BITS - 1);
    localparam logic [PW-1:0] LAST_BIT = PW'(NUMBER_OF_BITS);

    logic                      fall;
    logic [PW-1:0]             bit_pos;
    logic [PW-1:0]             next_pos;
    logic                      ws_next;
    logic                      sd_next;
    logic                      frame_start;
    logic                      data_slot;
    logic                      transfer;
    logic                      hold_full;
    logic [NUMBER_OF_BITS-1:0] hold_left;
    logic [NUMBER_OF_BITS-1:0] hold_right;
    logic [NUMBER_OF_BITS-1:0] shift_left;
    logic [NUMBER_OF_BITS-1:0] shift_right;

    pcm_to_i2s_sck_divider #(
        .SCK_DIV(SCK_DIV)
    ) u_sck_divider (
        .clk  (clk),
        .reset(reset),
        .sck  (sck),
        .fall (fall)
    );

    assign sample_ready = !hold_full;
    assign transfer     = sample_valid && !hold_full;

    // Everything below describes the slot position that becomes current at the next fall strobe.
    always_comb begin
        next_pos    = (bit_pos == LAST_POS) ? '0 : bit_pos + PW'(1);
        ws_next     = (next_pos == '0) ? ~ws : ws;
        frame_start = fall && (next_pos == '0) && (ws == WS_RIGHT);
        data_slot   = (next_pos != '0) && (next_pos <= LAST_BIT);
        sd_next     = 1'b0;
        if (data_slot)
            sd_next = (ws_next == WS_LEFT) ? shift_left[NUMBER_OF_BITS-1]
                                           : shift_right[NUMBER_OF_BITS-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full   <= 1'b0;
            hold_left   <= '0;
            hold_right  <= '0;
            shift_left  <= '0;
            shift_right <= '0;
            bit_pos     <= LAST_POS;
            ws          <= WS_RIGHT;
            sd          <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            underrun <= frame_start && !hold_full;

            // ready is low while full, so a transfer never coincides with a frame-start load.
            if (transfer) begin
                hold_full  <= 1'b1;
                hold_left  <= data_left;
                hold_right <= data_right;
            end else if (frame_start) begin
                hold_full <= 1'b0;
            end

            if (fall) begin
                bit_pos <= next_pos;
                ws      <= ws_next;
                sd      <= sd_next;
                if (frame_start) begin
                    shift_left  <= hold_full ? hold_left  : '0;
                    shift_right <= hold_full ? hold_right : '0;
                end else if (data_slot) begin
                    if (ws_next == WS_LEFT)
                        shift_left <= shift_left << 1;
                    else
                        shift_right <= shift_right << 1;
                end
            end
        end
    end

endmodule
